// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// port indices, default geometry, and the address legality helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // A byte address is legal when it is word aligned and lands inside the BRAM.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with per-port mask; the last-grant pointer
// only advances when the caller accepts the grant.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       update_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic       last_q;
  logic [1:0] elig;

  assign elig = req_i & ~mask_i;

  always_comb begin
    gnt_valid_o = |elig;
    gnt_idx_o   = PORT_CPU;
    if (&elig) begin
      gnt_idx_o = ~last_q;
    end else if (elig[PORT_HOST]) begin
      gnt_idx_o = PORT_HOST;
    end
  end

  // Starting from "host served last" lets the CPU win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_HOST;
    end else if (update_i && gnt_valid_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data BRAM between the CPU load/store path and the
// host loader port; each access runs IDLE -> ACCESS -> ACK (or IDLE -> ACK on error).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [31:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  input  logic              host_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                grant_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   host_rdata_q;

  logic                gnt_valid;
  logic                gnt_idx;
  logic                arb_update;
  logic [31:0]         win_addr;
  logic                win_we;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_legal;
  logic                in_ack;
  logic                load_done;

  assign arb_update = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst),
    .req_i       ({host_req, cpu_req}),
    .mask_i      ({1'b0, host_lock}),
    .update_i    (arb_update),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign win_addr  = (gnt_idx == PORT_HOST) ? host_addr  : cpu_addr;
  assign win_we    = (gnt_idx == PORT_HOST) ? host_we    : cpu_we;
  assign win_wdata = (gnt_idx == PORT_HOST) ? host_wdata : cpu_wdata;
  assign win_legal = addr_legal(win_addr, ADDR_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_valid) state_d = win_legal ? ST_ACCESS : ST_ACK;
      ST_ACCESS: state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // addr_q/wdata_q double as the BRAM address/data outputs, so they only
  // move for legal accesses and otherwise hold their last values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= PORT_CPU;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && gnt_valid) begin
        grant_q <= gnt_idx;
        we_q    <= win_we;
        err_q   <= ~win_legal;
        if (win_legal) begin
          addr_q  <= win_addr[ADDR_W+1:2];
          wdata_q <= win_wdata;
        end
      end
      if (load_done) begin
        if (grant_q == PORT_HOST) host_rdata_q <= mem_rdata;
        else                      cpu_rdata_q  <= mem_rdata;
      end
    end
  end

  assign in_ack    = (state_q == ST_ACK);
  assign load_done = in_ack & ~we_q & ~err_q;

  assign cpu_ack    = in_ack & (grant_q == PORT_CPU);
  assign host_ack   = in_ack & (grant_q == PORT_HOST);
  assign cpu_err    = cpu_ack & err_q;
  assign host_err   = host_ack & err_q;
  assign cpu_rdata  = (cpu_ack  & load_done) ? mem_rdata : cpu_rdata_q;
  assign host_rdata = (host_ack & load_done) ? mem_rdata : host_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_ack;

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner-case
// sequences, then random two-port traffic against a transaction-level model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack, cpu_err, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [31:0]   host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack, host_err;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          init_pulse = 1'b0;
  logic [DW-1:0] bram [1024];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err), .host_lock(host_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // BRAM with registered read, one-cycle latency.
  always @(posedge clk) begin
    if (init_pulse) begin
      for (int i = 0; i < 1024; i++) bram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; init_pulse = 1'b1;
    cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1; init_pulse = 1'b0; rst = 1'b1;
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output bit err, output logic [31:0] rd, output int en_cnt,
                        output logic [AW-1:0] maddr, output logic [31:0] mwd, output bit mwe,
                        output int stall_cnt);
    lat = -1; err = 1'b0; rd = '0; en_cnt = 0; maddr = '0; mwd = '0; mwe = 1'b0; stall_cnt = 0;
    @(posedge clk); #1;
    if (port) begin host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd; end
    else      begin cpu_req  = 1'b1; cpu_we  = we; cpu_addr  = addr; cpu_wdata  = wd; end
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin en_cnt++; maddr = mem_addr; mwd = mem_wdata; mwe = mem_we; end
      if (cpu_stall) stall_cnt++;
      if (port ? host_ack : cpu_ack) begin
        lat = k;
        err = port ? host_err : cpu_err;
        rd  = port ? host_rdata : cpu_rdata;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  // Both ports already requesting; sampling index starts at k0. Drops each req after its ack.
  task automatic watch_acks(input int k0, output int clat, output int hlat,
                            output logic [31:0] crd, output logic [31:0] hrd);
    bit c_now, h_now;
    clat = -1; hlat = -1; crd = '0; hrd = '0;
    for (int k = k0; k < k0 + 14 && (clat < 0 || hlat < 0); k++) begin
      @(negedge clk);
      c_now = cpu_ack; h_now = host_ack;
      if (c_now && clat < 0) begin clat = k; crd = cpu_rdata; end
      if (h_now && hlat < 0) begin hlat = k; hrd = host_rdata; end
      @(posedge clk); #1;
      if (c_now) cpu_req = 1'b0;
      if (h_now) host_req = 1'b0;
    end
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    case ($urandom_range(0, 7))
      0: a = a | 32'($urandom_range(1, 3));
      1: a = a | (32'd1 << $urandom_range(12, 31));
      default: ;
    endcase
    return a;
  endfunction

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_en;
    logic [AW-1:0] exp_maddr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int lat, en_cnt, stall_cnt, clat, hlat, acks, stalls;
    bit err, mwe;
    logic [31:0] rd, mwd, crd, hrd;
    logic [AW-1:0] maddr;

    tbl[0]  = '{0, 1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        2, 1, 10'h004};
    tbl[1]  = '{0, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 2, 1, 10'h004};
    tbl[2]  = '{0, 0, 32'h13,       32'h0,        1, 32'hDEADBEEF, 1, 0, 10'h000};
    tbl[3]  = '{0, 0, 32'h1000,     32'h0,        1, 32'hDEADBEEF, 1, 0, 10'h000};
    tbl[4]  = '{1, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 2, 1, 10'h004};
    tbl[5]  = '{1, 1, 32'hFFC,      32'h12345678, 0, 32'hDEADBEEF, 2, 1, 10'h3FF};
    tbl[6]  = '{0, 0, 32'hFFC,      32'h0,        0, 32'h12345678, 2, 1, 10'h3FF};
    tbl[7]  = '{1, 0, 32'h80,       32'h0,        0, 32'hC0DE0020, 2, 1, 10'h020};
    tbl[8]  = '{1, 1, 32'h80000000, 32'h0BADF00D, 1, 32'hC0DE0020, 1, 0, 10'h000};
    tbl[9]  = '{0, 0, 32'h200,      32'h0,        0, 32'hC0DE0080, 2, 1, 10'h080};
    tbl[10] = '{0, 1, 32'h2,        32'h11111111, 1, 32'hC0DE0080, 1, 0, 10'h000};

    do_reset();
    chk("rst cpu_ack",    32'(cpu_ack),  32'd0);
    chk("rst host_ack",   32'(host_ack), 32'd0);
    chk("rst mem_en",     32'(mem_en),   32'd0);
    chk("rst mem_addr",   32'(mem_addr), 32'd0);
    chk("rst mem_wdata",  mem_wdata,     32'd0);
    chk("rst cpu_rdata",  cpu_rdata,     32'd0);
    chk("rst host_rdata", host_rdata,    32'd0);
    chk("rst cpu_stall",  32'(cpu_stall), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
             lat, err, rd, en_cnt, maddr, mwd, mwe, stall_cnt);
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d mem_en cycles", i), 32'(en_cnt), 32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d stall cycles", i), 32'(stall_cnt),
          tbl[i].port ? 32'd0 : 32'(tbl[i].exp_lat));
      if (tbl[i].exp_en > 0) begin
        chk($sformatf("tbl%0d mem_addr", i), 32'(maddr), 32'(tbl[i].exp_maddr));
        chk($sformatf("tbl%0d mem_we", i), 32'(mwe), 32'(tbl[i].we));
        if (tbl[i].we) chk($sformatf("tbl%0d mem_wdata", i), mwd, tbl[i].wdata);
      end
    end

    // Tie right after reset: CPU first, then host.
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h24;
    watch_acks(0, clat, hlat, crd, hrd);
    chk("tie1 cpu lat",  32'(clat), 32'd2);
    chk("tie1 host lat", 32'(hlat), 32'd5);
    chk("tie1 cpu rdata",  crd, 32'hC0DE0008);
    chk("tie1 host rdata", hrd, 32'hC0DE0009);

    // CPU alone takes a grant, so the next tie goes to the host.
    do_txn(0, 0, 32'h28, 32'h0, lat, err, rd, en_cnt, maddr, mwd, mwe, stall_cnt);
    chk("solo cpu rdata", rd, 32'hC0DE000A);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2C;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h30;
    watch_acks(0, clat, hlat, crd, hrd);
    chk("tie2 host lat", 32'(hlat), 32'd2);
    chk("tie2 cpu lat",  32'(clat), 32'd5);

    // Host lock starves the CPU until it is dropped.
    @(posedge clk); #1;
    host_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    acks = 0; stalls = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (cpu_stall) stalls++;
    end
    chk("lock cpu acks",  32'(acks),   32'd0);
    chk("lock cpu stall", 32'(stalls), 32'd8);
    @(posedge clk); #1;
    host_lock = 1'b0;
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = k; rd = cpu_rdata; end
    end
    chk("unlock cpu lat",   32'(lat), 32'd2);
    chk("unlock cpu rdata", rd, 32'hC0DE000C);
    @(posedge clk); #1; cpu_req = 1'b0;

    // Lock raised while the CPU access is in flight.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h34;
    @(negedge clk);
    @(posedge clk); #1;
    host_lock = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 32'h38;
    watch_acks(1, clat, hlat, crd, hrd);
    chk("lockmid cpu lat",  32'(clat), 32'd2);
    chk("lockmid host lat", 32'(hlat), 32'd5);
    chk("lockmid host rdata", hrd, 32'hC0DE000E);
    host_lock = 1'b0;

    // Reset in the middle of a host store.
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_wdata = 32'h55AA55AA;
    @(posedge clk); #2;
    chk("rmid mem_en before", 32'(mem_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("rmid mem_en",    32'(mem_en),   32'd0);
    chk("rmid mem_we",    32'(mem_we),   32'd0);
    chk("rmid mem_addr",  32'(mem_addr), 32'd0);
    chk("rmid mem_wdata", mem_wdata,     32'd0);
    chk("rmid host_ack",  32'(host_ack), 32'd0);
    chk("rmid host_rdata", host_rdata,   32'd0);
    chk("rmid cpu_rdata", cpu_rdata,     32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      if (host_ack) lat = k;
    end
    chk("rmid store lat", 32'(lat), 32'd2);
    @(posedge clk); #1; host_req = 1'b0;
    do_txn(1, 0, 32'h40, 32'h0, lat, err, rd, en_cnt, maddr, mwd, mwe, stall_cnt);
    chk("rmid readback", rd, 32'h55AA55AA);

    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Transaction-level model: the shared memory is free again one cycle after
  // each ack; a legal access acks two cycles after its grant, an illegal one
  // cycle after. Ties go to whichever port was not granted last.
  task automatic run_random();
    logic [31:0] shadow [1024];
    bit          pend [2];
    bit          drop [2];
    bit          p_we [2];
    bit          t_err [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    logic [31:0] last_rd [2];
    int          ack_at [2];
    int          free_at, acc_at, w, last_g;
    bit          e0, e1, exp_a, act_a, act_e;
    logic [31:0] act_rd;
    logic [AW-1:0] acc_addr;
    bit          acc_we;
    logic [31:0] acc_wd;

    do_reset();
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; drop[p] = 0; p_we[p] = 0; t_err[p] = 0;
      p_addr[p] = '0; p_wd[p] = '0; last_rd[p] = '0; ack_at[p] = -1;
    end
    free_at = 0; acc_at = -1; last_g = 1; acc_addr = '0; acc_we = 0; acc_wd = '0;

    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (drop[p]) begin pend[p] = 0; drop[p] = 0; end
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]   = 1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = rand_addr();
          p_wd[p]   = $urandom();
        end
      end
      if ($urandom_range(0, 15) == 0) host_lock = ~host_lock;
      cpu_req  = pend[0]; cpu_we  = p_we[0]; cpu_addr  = p_addr[0]; cpu_wdata  = p_wd[0];
      host_req = pend[1]; host_we = p_we[1]; host_addr = p_addr[1]; host_wdata = p_wd[1];

      if (cyc >= free_at) begin
        e0 = pend[0] && !host_lock;
        e1 = pend[1];
        if (e0 || e1) begin
          if (e0 && e1) w = (last_g == 0) ? 1 : 0;
          else          w = e1 ? 1 : 0;
          last_g   = w;
          t_err[w] = !((p_addr[w][1:0] == 2'b00) && (p_addr[w][31:12] == 20'd0));
          ack_at[w] = cyc + (t_err[w] ? 1 : 2);
          if (!t_err[w]) begin
            acc_at   = cyc + 1;
            acc_addr = p_addr[w][11:2];
            acc_we   = p_we[w];
            acc_wd   = p_wd[w];
          end
          free_at = ack_at[w] + 1;
        end
      end

      @(negedge clk);
      chk("rnd mem_en", 32'(mem_en), 32'(acc_at == cyc));
      if (acc_at == cyc) begin
        chk("rnd mem_addr", 32'(mem_addr), 32'(acc_addr));
        chk("rnd mem_we", 32'(mem_we), 32'(acc_we));
        if (acc_we) chk("rnd mem_wdata", mem_wdata, acc_wd);
      end
      chk("rnd cpu_stall", 32'(cpu_stall), 32'(pend[0] && ack_at[0] != cyc));
      for (int p = 0; p < 2; p++) begin
        exp_a  = (ack_at[p] == cyc);
        act_a  = p ? host_ack : cpu_ack;
        act_e  = p ? host_err : cpu_err;
        act_rd = p ? host_rdata : cpu_rdata;
        chk($sformatf("rnd ack p%0d c%0d", p, cyc), 32'(act_a), 32'(exp_a));
        chk($sformatf("rnd err p%0d c%0d", p, cyc), 32'(act_e), 32'(exp_a && t_err[p]));
        if (exp_a) begin
          if (!t_err[p] && !p_we[p]) last_rd[p] = shadow[p_addr[p][11:2]];
          else if (!t_err[p] && p_we[p]) shadow[p_addr[p][11:2]] = p_wd[p];
          drop[p] = 1; ack_at[p] = -1;
        end
        chk($sformatf("rnd rdata p%0d c%0d", p, cyc), act_rd, last_rd[p]);
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
  endtask

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 1024×32 data BRAM between two requesters:
- the CPU load/store path (port 0);
- a host loader/debug port (port 1) that fills and inspects memory while the CPU is halted or running.

Conflicts are resolved round-robin, with a host lock for debug bursts. The block sequences each access through a three-state FSM, checks address legality, and raises `cpu_stall` while the CPU's access is pending.

## Interface
- `ADDR_W`, 10, word-address width of the BRAM (1024 words)
- `DATA_W`, 32, data width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU access request, held stable until `cpu_ack`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  32  byte address
- `cpu_wdata`  in  DATA_W  store data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  load data, valid with `cpu_ack`
- `cpu_err`  out  1  illegal address, valid with `cpu_ack`
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack` (combinational)
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`, `host_rdata`, `host_err`: same as CPU port, for the host
- `host_lock`  in  1  while high, the CPU is never granted
- `mem_en`  out  1  BRAM enable
- `mem_we`  out  1  BRAM write enable
- `mem_addr`  out  ADDR_W  word address, `= addr[ADDR_W+1:2]`
- `mem_wdata`  out  DATA_W  BRAM write data
- `mem_rdata`  in  DATA_W  BRAM read data, registered inside the BRAM (1-cycle latency)

## Operation
- States: IDLE, ACCESS, ACK.
- **IDLE:** evaluate requests.
  - If none, stay in IDLE.
  - Otherwise choose a winner, latch `grant`, `we`, `addr` and `wdata`.
  - Legal address: go to ACCESS.
  - Illegal address: set the error flag and go to ACK directly, with no BRAM access.
- **Legality:** `addr[1:0]==0` and `addr[31:ADDR_W+2]==0`.
- **ACCESS:** `mem_en=1`, `mem_we=we`, `mem_addr` and `mem_wdata` driven from the latched values. Always go to ACK.
- **ACK:**
  - Pulse the winner's ack.
  - Winner's rdata = `mem_rdata` for a load; err = error flag.
  - Go to IDLE.
- **Arbitration:**
  - Only one requester active: it wins, except the CPU is blocked while `host_lock=1`.
  - Both active: the port not granted last wins. The last-grant register updates on each grant.
- `host_lock` rising during a CPU access does not abort it; it takes effect at the next IDLE.
- **Requester rule:** the requester deasserts `req` on the edge where it sees ack. A `req` still high in the following IDLE cycle is a new access.
- **rdata outputs:** outside ACK, each port's rdata holds the value captured at the end of its last load ACK. Stores and errors leave it unchanged.
- **Outputs outside ACCESS:** `mem_en=mem_we=0`; `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Legal access (load or store): request seen in IDLE at cycle N; ACCESS at N+1; ack at N+2.
- Illegal access: ack + err at N+1.
- Maximum throughput: one legal access per 3 cycles.
- Back-to-back contention alternates ports:
  - the CPU is served every 6 cycles worst case;
  - the CPU is starved indefinitely while `host_lock=1`.
- Reset (asserted at any time, including mid-access):
  - state IDLE;
  - last-grant = host, so the CPU wins the first tie;
  - all acks, errs, `mem_en`, `mem_we` = 0;
  - `mem_addr`, `mem_wdata`, rdata outputs = 0.

  An interrupted access is dropped. A requester still holding `req` after reset release is served as a new access.
- `cpu_stall` has no state. It is 1 from the first cycle `cpu_req` is high through the cycle before `cpu_ack`.

## Structure
- Shared package:
  - state encoding `{IDLE, ACCESS, ACK}`;
  - port-index constants `PORT_CPU=0`, `PORT_HOST=1`;
  - `ADDR_W` and `DATA_W` defaults.
- Sub-module `rr_arb2`: registered last-grant pointer, combinational two-way round-robin grant with mask input (`host_lock` masks the CPU), and an update enable asserted only in IDLE on grant. The FSM, latches, legality check and output muxing stay in `dmem_arbiter`.

## Test plan
- **CPU store then load.** CPU store `addr=0x10`, `wdata=0xDEADBEEF`: `mem_en=mem_we=1`, `mem_addr=4` at N+1, `cpu_ack` at N+2. Then CPU load `0x10`: `cpu_rdata=0xDEADBEEF` with `cpu_ack` 3 cycles after request; `cpu_stall` high for exactly 2 cycles.
- **Simultaneous requests after reset.** Both request in the same cycle: CPU acked at N+2, host's access starts in the following IDLE and is acked at N+5. Repeat the tie: host wins this time.
- **Host lock.** `host_lock=1`, CPU requests with no host request: no grant and `cpu_stall` stays 1. Drop the lock: CPU acked 3 cycles later.
- **Illegal addresses.** CPU load at `0x13` (misaligned) and at `0x1000` (out of range): `cpu_ack=cpu_err=1` at N+1, `mem_en` never asserted, `cpu_rdata` unchanged.
- **Reset mid-access.** Assert `rst=0` during ACCESS of a host store: all outputs 0 immediately. Release with `host_req` still high: the store completes 3 cycles after release.
- **Lock during CPU access.** Raise `host_lock` while the CPU is in ACCESS: the CPU is still acked, and the host is served next.
